// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add MUL/SMUL/UMUL and restoring unsigned DIV.
// Optional MULDIV_FAST_MUL_EN: multiplies use one combinational 2W product and complete in one cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       NZ,
  output logic             DivZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] OP_MUL = 2'b00, OP_SMUL = 2'b01, OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_op;
  logic             r_neg;
  logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_resLo, r_resHi;
  logic [1:0]       r_nz;
  logic             r_divZero;

  logic             w_accept, w_fast, w_isSmul, w_isDiv;
  logic [WIDTH-1:0] w_absA, w_absB, w_opA, w_opB;
  logic [WIDTH:0]   w_sum, w_remShift, w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_stepHi, w_stepLo;
  logic [1:0]       w_finOp;
  logic             w_finNeg, w_finDz;
  logic [WIDTH-1:0] w_finHi, w_finLo;
  logic [2*WIDTH-1:0] w_prod, w_sprod;
  logic [WIDTH-1:0] w_resLo, w_resHi;
  logic [1:0]       w_nz;
  logic             w_dz;

  assign w_accept = Start && ALUControl[2] && (r_state != CALC);
  assign w_isSmul = (ALUControl[1:0] == OP_SMUL);
  assign w_isDiv  = (ALUControl[1:0] == OP_DIV);
  assign w_absA   = SrcA[WIDTH-1] ? -SrcA : SrcA;
  assign w_absB   = SrcB[WIDTH-1] ? -SrcB : SrcB;
  assign w_opA    = w_isSmul ? w_absA : SrcA;
  assign w_opB    = w_isSmul ? w_absB : SrcB;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fastProd;
  assign w_fastProd = {{WIDTH{1'b0}}, w_opA} * {{WIDTH{1'b0}}, w_opB};
  assign w_fast     = w_accept && !w_isDiv;
`else
  assign w_fast     = 1'b0;
`endif

  // r_lo doubles as multiplier (shifted out LSB-first) or dividend/quotient (shifted MSB-first)
  assign w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_remShift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff     = w_remShift - {1'b0, r_opnd};
  assign w_ge       = !w_diff[WIDTH];

  always_comb begin
    if (r_op == OP_DIV) begin
      w_stepHi = w_ge ? w_diff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
      w_stepLo = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_stepHi = w_sum[WIDTH:1];
      w_stepLo = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_finOp  = r_op;
    w_finNeg = r_neg;
    w_finHi  = w_stepHi;
    w_finLo  = w_stepLo;
    w_finDz  = (r_opnd == '0);
`ifdef MULDIV_FAST_MUL_EN
    if (w_fast) begin
      w_finOp  = ALUControl[1:0];
      w_finNeg = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
      {w_finHi, w_finLo} = w_fastProd;
      w_finDz  = 1'b0;
    end
`endif
  end

  // Shape the raw product/quotient into the architectural results and flags
  always_comb begin
    w_prod  = {w_finHi, w_finLo};
    w_sprod = w_finNeg ? -w_prod : w_prod;
    w_resLo = w_prod[WIDTH-1:0];
    w_resHi = w_prod[2*WIDTH-1:WIDTH];
    w_dz    = 1'b0;
    w_nz    = {w_prod[2*WIDTH-1], (w_prod == '0)};
    case (w_finOp)
      OP_MUL: begin
        w_resHi = '0;
        w_nz    = {w_prod[WIDTH-1], (w_prod[WIDTH-1:0] == '0)};
      end
      OP_SMUL: begin
        w_resLo = w_sprod[WIDTH-1:0];
        w_resHi = w_sprod[2*WIDTH-1:WIDTH];
        w_nz    = {w_sprod[2*WIDTH-1], (w_sprod == '0)};
      end
      OP_DIV: begin
        w_nz = {w_finLo[WIDTH-1], (w_finLo == '0)};
        w_dz = w_finDz;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept)              w_next = w_fast ? DONE : CALC;
        else if (r_state == DONE)  w_next = IDLE;
      end
      CALC:    if (r_cnt == LAST) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_resLo   <= '0;
      r_resHi   <= '0;
      r_nz      <= '0;
      r_divZero <= 1'b0;
    end else if (w_accept) begin
      r_op   <= ALUControl[1:0];
      r_neg  <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
      r_hi   <= '0;
      r_lo   <= w_isDiv ? SrcA : w_opB;
      r_opnd <= w_isDiv ? SrcB : w_opA;
      r_cnt  <= '0;
      if (w_fast) begin
        r_resLo   <= w_resLo;
        r_resHi   <= w_resHi;
        r_nz      <= w_nz;
        r_divZero <= w_dz;
      end
    end else if (r_state == CALC) begin
      r_hi  <= w_stepHi;
      r_lo  <= w_stepLo;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        r_resLo   <= w_resLo;
        r_resHi   <= w_resHi;
        r_nz      <= w_nz;
        r_divZero <= w_dz;
      end
    end
  end

  assign Busy     = (r_state == CALC);
  assign Done     = (r_state == DONE);
  assign ResultLo = r_resLo;
  assign ResultHi = r_resHi;
  assign NZ       = r_nz;
  assign DivZero  = r_divZero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; expected latencies follow MULDIV_FAST_MUL_EN if defined.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  ALUControl = 3'b000;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic        Busy, Done, DivZero;
  logic [31:0] ResultLo, ResultHi;
  logic [1:0]  NZ;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
    .ResultLo(ResultLo), .ResultHi(ResultHi), .NZ(NZ), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  // Called at a negedge; operands are scrambled right after the accepting edge
  task automatic start_op(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; ALUControl = ctrl; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0; ALUControl = 3'b000; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678;
  endtask

  task automatic wait_done(output int cycles, output logic busyFirst);
    cycles = 0; busyFirst = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) busyFirst = Busy;
      if (Done) begin cycles = i; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({Busy, Done, DivZero} !== 3'b000) begin failures++; $display("[TB] FAIL reset_ctrl got=%b exp=000", {Busy, Done, DivZero}); end
    checks++; if ({ResultHi, ResultLo} !== 64'h0) begin failures++; $display("[TB] FAIL reset_result got=%h exp=0", {ResultHi, ResultLo}); end
    checks++; if (NZ !== 2'b00) begin failures++; $display("[TB] FAIL reset_nz got=%b exp=00", NZ); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_umul;
    int cyc; logic bz;
    start_op(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bz);
    checks++; if (cyc !== MUL_LAT) begin failures++; $display("[TB] FAIL umul_latency got=%0d exp=%0d", cyc, MUL_LAT); end
    checks++; if (bz !== (MUL_LAT > 1)) begin failures++; $display("[TB] FAIL umul_busy got=%b exp=%b", bz, (MUL_LAT > 1)); end
    checks++; if (ResultHi !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL umul_hi got=%h exp=fffffffe", ResultHi); end
    checks++; if (ResultLo !== 32'h0000_0001) begin failures++; $display("[TB] FAIL umul_lo got=%h exp=00000001", ResultLo); end
    checks++; if ({NZ, DivZero} !== 3'b100) begin failures++; $display("[TB] FAIL umul_flags got=%b exp=100", {NZ, DivZero}); end
    @(negedge clk);
    checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL umul_done_pulse got=%b exp=0", Done); end
  endtask

  task automatic test_smul;
    int cyc; logic bz;
    start_op(3'b101, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc, bz);
    checks++; if (cyc !== MUL_LAT) begin failures++; $display("[TB] FAIL smul_latency got=%0d exp=%0d", cyc, MUL_LAT); end
    checks++; if ({ResultHi, ResultLo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("[TB] FAIL smul_neg got=%h exp=ffffffffffffffeb", {ResultHi, ResultLo}); end
    checks++; if (NZ !== 2'b10) begin failures++; $display("[TB] FAIL smul_neg_nz got=%b exp=10", NZ); end
    @(negedge clk);
    start_op(3'b101, 32'h8000_0000, 32'h8000_0000);
    wait_done(cyc, bz);
    checks++; if ({ResultHi, ResultLo} !== 64'h4000_0000_0000_0000) begin failures++; $display("[TB] FAIL smul_minint got=%h exp=4000000000000000", {ResultHi, ResultLo}); end
    checks++; if (NZ !== 2'b00) begin failures++; $display("[TB] FAIL smul_minint_nz got=%b exp=00", NZ); end
    @(negedge clk);
  endtask

  task automatic test_div;
    int cyc; logic bz;
    start_op(3'b111, 32'd100, 32'd7);
    wait_done(cyc, bz);
    checks++; if (cyc !== DIV_LAT) begin failures++; $display("[TB] FAIL div_latency got=%0d exp=%0d", cyc, DIV_LAT); end
    checks++; if ({ResultHi, ResultLo} !== {32'd2, 32'd14}) begin failures++; $display("[TB] FAIL div_result got=%h exp=%h", {ResultHi, ResultLo}, {32'd2, 32'd14}); end
    checks++; if ({NZ, DivZero} !== 3'b000) begin failures++; $display("[TB] FAIL div_flags got=%b exp=000", {NZ, DivZero}); end
    @(negedge clk);
    start_op(3'b111, 32'd5, 32'd0);
    wait_done(cyc, bz);
    checks++; if (cyc !== DIV_LAT) begin failures++; $display("[TB] FAIL divzero_latency got=%0d exp=%0d", cyc, DIV_LAT); end
    checks++; if ({ResultHi, ResultLo} !== {32'd5, 32'hFFFF_FFFF}) begin failures++; $display("[TB] FAIL divzero_result got=%h exp=%h", {ResultHi, ResultLo}, {32'd5, 32'hFFFF_FFFF}); end
    checks++; if ({NZ, DivZero} !== 3'b101) begin failures++; $display("[TB] FAIL divzero_flags got=%b exp=101", {NZ, DivZero}); end
    @(negedge clk);
  endtask

  task automatic test_mul_zero_and_invalid;
    int cyc; logic bz; logic seen;
    start_op(3'b100, 32'd0, 32'd123);
    wait_done(cyc, bz);
    checks++; if (cyc !== MUL_LAT) begin failures++; $display("[TB] FAIL mul_latency got=%0d exp=%0d", cyc, MUL_LAT); end
    checks++; if ({ResultHi, ResultLo} !== 64'h0) begin failures++; $display("[TB] FAIL mul_zero got=%h exp=0", {ResultHi, ResultLo}); end
    checks++; if (NZ !== 2'b01) begin failures++; $display("[TB] FAIL mul_zero_nz got=%b exp=01", NZ); end
    @(negedge clk);
    start_op(3'b010, 32'd9, 32'd9);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Busy || Done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL invalid_op_activity got=%b exp=0", seen); end
  endtask

  task automatic test_midcalc_start;
    int cyc; logic bz; logic seen;
    start_op(3'b111, 32'd1000, 32'd10);
    repeat (4) @(negedge clk);
    start_op(3'b111, 32'd9, 32'd3);
    wait_done(cyc, bz);
    checks++; if (cyc === 0) begin failures++; $display("[TB] FAIL midcalc_timeout got=%0d exp=done", cyc); end
    checks++; if ({ResultHi, ResultLo} !== {32'd0, 32'd100}) begin failures++; $display("[TB] FAIL midcalc_result got=%h exp=%h", {ResultHi, ResultLo}, {32'd0, 32'd100}); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done || Busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL midcalc_extra_op got=%b exp=0", seen); end
  endtask

  task automatic test_back_to_back;
    int cyc; logic bz;
    start_op(3'b111, 32'd50, 32'd7);
    wait_done(cyc, bz);
    checks++; if ({ResultHi, ResultLo} !== {32'd1, 32'd7}) begin failures++; $display("[TB] FAIL b2b_first got=%h exp=%h", {ResultHi, ResultLo}, {32'd1, 32'd7}); end
    start_op(3'b111, 32'd20, 32'd6);
    @(negedge clk);
    checks++; if ({Busy, Done} !== 2'b10) begin failures++; $display("[TB] FAIL b2b_busy got=%b exp=10", {Busy, Done}); end
    checks++; if (ResultLo !== 32'd7) begin failures++; $display("[TB] FAIL b2b_hold got=%h exp=%h", ResultLo, 32'd7); end
    wait_done(cyc, bz);
    checks++; if (cyc !== DIV_LAT - 1) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=%0d", cyc, DIV_LAT - 1); end
    checks++; if ({ResultHi, ResultLo} !== {32'd2, 32'd3}) begin failures++; $display("[TB] FAIL b2b_second got=%h exp=%h", {ResultHi, ResultLo}, {32'd2, 32'd3}); end
    @(negedge clk);
  endtask

  task automatic test_reset_midcalc;
    logic seen;
    start_op(3'b111, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({Busy, Done, DivZero, NZ} !== 5'b0) begin failures++; $display("[TB] FAIL rstmid_ctrl got=%b exp=00000", {Busy, Done, DivZero, NZ}); end
    checks++; if ({ResultHi, ResultLo} !== 64'h0) begin failures++; $display("[TB] FAIL rstmid_result got=%h exp=0", {ResultHi, ResultLo}); end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done || Busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done got=%b exp=0", seen); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_umul();
    test_smul();
    test_div();
    test_mul_zero_and_invalid();
    test_midcalc_start();
    test_back_to_back();
    test_reset_midcalc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
